// File: rtl/gen_skid_reg.sv
// rtl/gen_skid_reg.sv - valid/ready pipeline register with two-entry skid buffer and flush
// Optional statistics counters are enabled with GEN_SKID_REG_STATS_EN.
module gen_skid_reg #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
`ifdef GEN_SKID_REG_STATS_EN
    ,
    parameter int                    CNT_WIDTH   = 16
`endif
) (
    input  logic                  reg_clock_input,
    input  logic                  reg_input_reset,
    input  logic [DATA_WIDTH-1:0] reg_input_data,
    input  logic                  reg_input_valid,
    output logic                  reg_input_ready,
    input  logic                  reg_input_flush,
    output logic [DATA_WIDTH-1:0] reg_output_data,
    output logic                  reg_output_valid,
    input  logic                  reg_output_ready
`ifdef GEN_SKID_REG_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  reg_stat_xfer_count,
    output logic [CNT_WIDTH-1:0]  reg_stat_stall_count
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  ready_q, ready_d;
    logic                  in_fire, out_fire;

    assign in_fire          = reg_input_valid & ready_q;
    assign out_fire         = reg_output_valid & reg_output_ready;
    assign reg_input_ready  = ready_q;
    assign reg_output_valid = (state_q != ST_EMPTY);
    assign reg_output_data  = main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_BUSY;
                    main_d  = reg_input_data;
                end
            end
            ST_BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = reg_input_data;
                end else if (in_fire) begin
                    state_d = ST_FULL;
                    skid_d  = reg_input_data;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_d = ST_BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush wins over every transition; data is left as-is since it is invalid afterwards.
        if (reg_input_flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
        ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge reg_clock_input or posedge reg_input_reset) begin
        if (reg_input_reset) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

`ifdef GEN_SKID_REG_STATS_EN
    logic [CNT_WIDTH-1:0] xfer_q, xfer_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;

    always_comb begin
        xfer_d  = xfer_q;
        stall_d = stall_q;
        if (out_fire) begin
            xfer_d = xfer_q + 1'b1;
        end
        if (reg_output_valid && !reg_output_ready) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge reg_clock_input or posedge reg_input_reset) begin
        if (reg_input_reset) begin
            xfer_q  <= '0;
            stall_q <= '0;
        end else begin
            xfer_q  <= xfer_d;
            stall_q <= stall_d;
        end
    end

    assign reg_stat_xfer_count  = xfer_q;
    assign reg_stat_stall_count = stall_q;
`endif

endmodule

// File: tb/tb_gen_skid_reg.sv
// tb/tb_gen_skid_reg.sv - directed and randomized scoreboard bench for gen_skid_reg
module tb_gen_skid_reg;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          flush = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
`ifdef GEN_SKID_REG_STATS_EN
    logic [CW-1:0] xfer_cnt;
    logic [CW-1:0] stall_cnt;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    logic [DW-1:0] exp_q[$];
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    int            stall_tally = 0;
    int            rcv_n = 0;

    always #5 clk = ~clk;

    gen_skid_reg #(
        .DATA_WIDTH (DW),
        .RESET_VALUE('0)
`ifdef GEN_SKID_REG_STATS_EN
        ,
        .CNT_WIDTH  (CW)
`endif
    ) dut (
        .reg_clock_input (clk),
        .reg_input_reset (rst),
        .reg_input_data  (in_data),
        .reg_input_valid (in_valid),
        .reg_input_ready (in_ready),
        .reg_input_flush (flush),
        .reg_output_data (out_data),
        .reg_output_valid(out_valid),
        .reg_output_ready(out_ready)
`ifdef GEN_SKID_REG_STATS_EN
        ,
        .reg_stat_xfer_count (xfer_cnt),
        .reg_stat_stall_count(stall_cnt)
`endif
    );

    task automatic check_vec(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; drives one cycle of inputs, checks against the model, advances one edge.
    task automatic tick(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl,
                        output logic acc);
        logic outf;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_vec("valid", {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
        check_vec("ready", {31'b0, in_ready}, {31'b0, exp_q.size() < 2});
        if (stall_prev) begin
            check_vec("stable", out_data, prev_data);
        end
        outf = out_valid & ordy;
        acc  = v & in_ready;
        if (outf && exp_q.size() > 0) begin
            check_vec("order", out_data, exp_q.pop_front());
            rcv_n++;
        end
        if (exp_q.size() > 0 && !ordy) begin
            stall_tally++;
        end
        if (fl) begin
            exp_q.delete();
        end else if (acc) begin
            exp_q.push_back(d);
        end
        stall_prev = out_valid & !ordy & !fl;
        prev_data  = out_data;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #3 rst = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        exp_q.delete();
        stall_prev  = 1'b0;
        stall_tally = 0;
        rcv_n       = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic          acc;
        logic          pend;
        logic [DW-1:0] pdata;
        int            sent;
        int            cyc;

        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        check_vec("rst_valid", {31'b0, out_valid}, 32'd0);
        check_vec("rst_ready", {31'b0, in_ready}, 32'd1);
        check_vec("rst_data", out_data, 32'd0);

        // Reset mid-cycle while a payload is held, then 0xA5 right after release.
        tick(1'b1, 32'h77, 1'b0, 1'b0, acc);
        check_vec("held_77", out_data, 32'h77);
        in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_vec("async_valid", {31'b0, out_valid}, 32'd0);
        check_vec("async_ready", {31'b0, in_ready}, 32'd1);
        check_vec("async_data", out_data, 32'd0);
        #2 rst = 1'b0;
        in_data = 32'hA5;
        @(posedge clk);
        #1;
        check_vec("a5_valid", {31'b0, out_valid}, 32'd1);
        check_vec("a5_data", out_data, 32'hA5);
        exp_q.delete();
        exp_q.push_back(32'hA5);
        stall_prev = 1'b0;
        tick(1'b0, '0, 1'b1, 1'b0, acc);
        tick(1'b0, '0, 1'b1, 1'b0, acc);

        // Full-throughput stream.
        do_reset();
        for (int i = 0; i < 10; i++) tick(1'b1, i, 1'b1, 1'b0, acc);
        tick(1'b0, '0, 1'b1, 1'b0, acc);
        check_vec("stream_rcv", rcv_n, 32'd10);
`ifdef GEN_SKID_REG_STATS_EN
        check_vec("stream_xfer", {28'b0, xfer_cnt}, 32'd10);
        check_vec("stream_stall", {28'b0, stall_cnt}, 32'd0);
`endif

        // Skid fill and ordered drain.
        tick(1'b1, 32'h11, 1'b0, 1'b0, acc);
        tick(1'b1, 32'h22, 1'b0, 1'b0, acc);
        check_vec("full_main", out_data, 32'h11);
        check_vec("full_ready", {31'b0, in_ready}, 32'd0);
        tick(1'b1, 32'h33, 1'b0, 1'b0, acc);
        check_vec("33_refused", {31'b0, acc}, 32'd0);
        tick(1'b1, 32'h33, 1'b1, 1'b0, acc);
        tick(1'b1, 32'h33, 1'b1, 1'b0, acc);
        check_vec("33_taken", {31'b0, acc}, 32'd1);
        tick(1'b0, '0, 1'b1, 1'b0, acc);
        check_vec("drain_empty", exp_q.size(), 32'd0);

        // Flush from FULL with a concurrent valid input that must be discarded.
        tick(1'b1, 32'h55, 1'b0, 1'b0, acc);
        tick(1'b1, 32'h66, 1'b0, 1'b0, acc);
        tick(1'b1, 32'h44, 1'b0, 1'b1, acc);
        check_vec("flush_valid", {31'b0, out_valid}, 32'd0);
        check_vec("flush_ready", {31'b0, in_ready}, 32'd1);
        tick(1'b0, '0, 1'b1, 1'b0, acc);
        tick(1'b0, '0, 1'b1, 1'b0, acc);
        tick(1'b1, 32'h99, 1'b1, 1'b0, acc);
        check_vec("post_flush", out_data, 32'h99);
        tick(1'b0, '0, 1'b1, 1'b0, acc);

        // Random back-pressure with 500 payloads; upstream holds data while refused.
        do_reset();
        pend = 1'b0; pdata = '0; sent = 0; cyc = 0;
        while (cyc < 4000 && (sent < 500 || exp_q.size() > 0 || pend)) begin
            if (!pend && sent < 500 && ($urandom_range(3) != 0)) begin
                pend  = 1'b1;
                pdata = $urandom;
            end
            tick(pend, pdata, (cyc < 1000) ? ($urandom_range(1) == 1) : 1'b1, 1'b0, acc);
            if (acc) begin
                pend = 1'b0;
                sent++;
            end
            cyc++;
        end
        check_vec("rand_sent", sent, 32'd500);
        check_vec("rand_rcv", rcv_n, 32'd500);
`ifdef GEN_SKID_REG_STATS_EN
        check_vec("rand_stall", {28'b0, stall_cnt}, stall_tally % 16);
        check_vec("rand_xfer", {28'b0, xfer_cnt}, 500 % 16);

        do_reset();
        for (int i = 0; i < 17; i++) tick(1'b1, i, 1'b1, 1'b0, acc);
        tick(1'b0, '0, 1'b1, 1'b0, acc);
        check_vec("xfer_wrap", {28'b0, xfer_cnt}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
